// File: rtl/voice_operator_sequencer_pkg.sv
// Shared types for the voice operator sequencer.
// Build option SEQ_CFG_FIFO_EN: 4-entry host config FIFO instead of a single holding register.
package voice_operator_sequencer_pkg;

  localparam int NUM_VOICE_OPERATORS = 256;
  localparam int OP_ID_W             = $clog2(NUM_VOICE_OPERATORS);

  typedef logic [OP_ID_W-1:0] VoiceOperatorID_t;
  typedef logic [15:0]        PhaseStep_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    CFG_HI = 3'd3,
    CFG_LO = 3'd4
  } SeqState_t;

  typedef struct packed {
    VoiceOperatorID_t addr;
    PhaseStep_t       data;
  } CfgWrite_t;

`ifdef SEQ_CFG_FIFO_EN
  localparam bit CFG_FIFO_EN     = 1'b1;
  localparam int CFG_QUEUE_DEPTH = 4;
`else
  localparam bit CFG_FIFO_EN     = 1'b0;
  localparam int CFG_QUEUE_DEPTH = 1;
`endif

endpackage

// File: rtl/voice_operator_sequencer_cfg_write_queue.sv
// Pending host phase-step writes: one holding register, or a 4-entry FIFO with SEQ_CFG_FIFO_EN.
// next_data_o/more_o describe the head that follows a pop, so pairs can be issued back-to-back.
module voice_operator_sequencer_cfg_write_queue
  import voice_operator_sequencer_pkg::*;
(
  input  logic      i_Clock,
  input  logic      i_Reset,
  input  logic      push_valid_i,
  output logic      push_ready_o,
  input  CfgWrite_t push_data_i,
  output logic      pop_valid_o,
  input  logic      pop_ready_i,
  output CfgWrite_t pop_data_o,
  output CfgWrite_t next_data_o,
  output logic      more_o
);

  logic ready_q, ready_d;
  logic push_fire_s, pop_fire_s;

  assign push_ready_o = ready_q;
  assign push_fire_s  = push_valid_i && ready_q;
  assign pop_fire_s   = pop_ready_i && pop_valid_o;

`ifdef SEQ_CFG_FIFO_EN
  CfgWrite_t  mem_q [CFG_QUEUE_DEPTH];
  logic [1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;

  assign pop_valid_o = (count_q != 3'd0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign next_data_o = (count_q > 3'd1) ? mem_q[rd_ptr_q + 2'd1] : push_data_i;
  assign more_o      = (count_q > 3'd1) || push_fire_s;

  always_comb begin
    rd_ptr_d = pop_fire_s  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    wr_ptr_d = push_fire_s ? wr_ptr_q + 2'd1 : wr_ptr_q;
    count_d  = count_q + {2'b00, push_fire_s} - {2'b00, pop_fire_s};
    ready_d  = (count_d != 3'd4);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ready_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_fire_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end
`else
  CfgWrite_t entry_q, entry_d;
  logic      full_q, full_d;

  assign pop_valid_o = full_q;
  assign pop_data_o  = entry_q;
  assign next_data_o = entry_q;
  assign more_o      = 1'b0;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (push_fire_s) begin
      full_d  = 1'b1;
      entry_d = push_data_i;
    end else if (pop_fire_s) begin
      full_d  = 1'b0;
    end else begin
      full_d  = full_q;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      full_q  <= 1'b0;
      entry_q <= '0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
      ready_q <= ready_d;
    end
  end
`endif

endmodule

// File: rtl/voice_operator_sequencer.sv
// Issues operator IDs once per sample period and applies host phase-step writes between runs.
// SEQ_CFG_FIFO_EN (see package) lets several queued writes drain back-to-back per idle window.
module voice_operator_sequencer
  import voice_operator_sequencer_pkg::*;
#(
  parameter int NUM_OPS           = NUM_VOICE_OPERATORS,
  parameter int CLOCKS_PER_SAMPLE = 512,
  parameter int PIPE_DEPTH        = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_CfgValid,
  output logic             o_CfgReady,
  input  VoiceOperatorID_t i_CfgAddr,
  input  PhaseStep_t       i_CfgData,
  output VoiceOperatorID_t o_VoiceOperator,
  output logic             o_OperatorValid,
  output logic             o_SampleStart,
  output logic [1:0]       o_PhaseStepConfigWriteEnable,
  output VoiceOperatorID_t o_PhaseStepConfigWriteAddr,
  output logic [7:0]       o_PhaseStepConfigWriteData,
  output logic             o_Overrun
);

  localparam int CNT_W = $clog2(CLOCKS_PER_SAMPLE);
  localparam int DRN_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] TICK_AT    = CNT_W'(CLOCKS_PER_SAMPLE - 1);
  localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(PIPE_DEPTH - 1);
  localparam VoiceOperatorID_t LAST_OP    = VoiceOperatorID_t'(NUM_OPS - 1);

  SeqState_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  VoiceOperatorID_t op_id_q, op_id_d, waddr_q, waddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [1:0]       we_q, we_d;
  logic             tick_pend_q, tick_pend_d, cfg_done_q, cfg_done_d;
  logic             overrun_q, overrun_d, valid_q, valid_d, sstart_q, sstart_d;
  logic             tick_s, cfg_allow_s, pop_valid_s, more_s;
  CfgWrite_t        pop_data_s, next_data_s, hi_src_s;

  voice_operator_sequencer_cfg_write_queue u_cfg_queue (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .push_valid_i(i_CfgValid),
    .push_ready_o(o_CfgReady),
    .push_data_i ('{addr: i_CfgAddr, data: i_CfgData}),
    .pop_valid_o (pop_valid_s),
    .pop_ready_i (state_q == CFG_LO),
    .pop_data_o  (pop_data_s),
    .next_data_o (next_data_s),
    .more_o      (more_s)
  );

  assign tick_s      = (cnt_q == TICK_AT);
  assign cfg_allow_s = CFG_FIFO_EN || !cfg_done_q;
  // A pair chained straight from CFG_LO must present the entry behind the one being popped.
  assign hi_src_s    = (state_q == CFG_LO) ? next_data_s : pop_data_s;

  always_comb begin
    cnt_d       = tick_s ? '0 : cnt_q + CNT_W'(1);
    state_d     = state_q;
    op_id_d     = op_id_q;
    drain_d     = drain_q;
    tick_pend_d = tick_pend_q;
    cfg_done_d  = cfg_done_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (tick_s) begin
          state_d    = RUN;
          op_id_d    = '0;
          cfg_done_d = 1'b0;
        end else if (pop_valid_s && cfg_allow_s) begin
          state_d = CFG_HI;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        overrun_d = overrun_q | tick_s;
        if (op_id_q == LAST_OP) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          op_id_d = op_id_q + VoiceOperatorID_t'(1);
        end
      end
      DRAIN: begin
        overrun_d = overrun_q | tick_s;
        if (drain_q == LAST_DRAIN) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      CFG_HI: begin
        state_d     = CFG_LO;
        tick_pend_d = tick_pend_q | tick_s;
      end
      CFG_LO: begin
        cfg_done_d = 1'b1;
        if (tick_s || tick_pend_q) begin
          state_d     = RUN;
          op_id_d     = '0;
          tick_pend_d = 1'b0;
          cfg_done_d  = 1'b0;
        end else if (CFG_FIFO_EN && more_s) begin
          state_d = CFG_HI;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d  = (state_d == RUN);
    sstart_d = (state_d == RUN) && (state_q != RUN);
    we_d     = 2'b00;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_d)
      CFG_HI: begin
        we_d    = 2'b01;
        waddr_d = hi_src_s.addr;
        wdata_d = hi_src_s.data[15:8];
      end
      CFG_LO: begin
        we_d    = 2'b10;
        wdata_d = pop_data_s.data[7:0];
      end
      default: we_d = 2'b00;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      op_id_q     <= '0;
      tick_pend_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
      valid_q     <= 1'b0;
      sstart_q    <= 1'b0;
      we_q        <= 2'b00;
      waddr_q     <= '0;
      wdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      op_id_q     <= op_id_d;
      tick_pend_q <= tick_pend_d;
      cfg_done_q  <= cfg_done_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      sstart_q    <= sstart_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_VoiceOperator              = op_id_q;
  assign o_OperatorValid              = valid_q;
  assign o_SampleStart                = sstart_q;
  assign o_PhaseStepConfigWriteEnable = we_q;
  assign o_PhaseStepConfigWriteAddr   = waddr_q;
  assign o_PhaseStepConfigWriteData   = wdata_q;
  assign o_Overrun                    = overrun_q;

endmodule

// File: tb/tb_voice_operator_sequencer.sv
// Randomized host traffic on two sequencers (legal 512-clock period and an overrunning 260-clock one),
// compared every cycle against an activity-level reference model.
module tb_voice_operator_sequencer;

  localparam int NOPS = 256;
  localparam int PD   = 8;
  localparam int CPS0 = 512;
  localparam int CPS1 = 260;
`ifdef SEQ_CFG_FIFO_EN
  localparam int QDEPTH = 4;
  localparam bit FIFO   = 1'b1;
`else
  localparam int QDEPTH = 1;
  localparam bit FIFO   = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s [2];
  logic        cv    [2];
  logic [7:0]  ca    [2];
  logic [15:0] cd    [2];
  logic        rdy [2], vld [2], ss [2], ovr [2];
  logic [7:0]  vop [2], wa [2], wd [2];
  logic [1:0]  we  [2];

  voice_operator_sequencer #(.NUM_OPS(NOPS), .CLOCKS_PER_SAMPLE(CPS0), .PIPE_DEPTH(PD)) dut0 (
    .i_Clock(clk), .i_Reset(rst_s[0]), .i_CfgValid(cv[0]), .o_CfgReady(rdy[0]),
    .i_CfgAddr(ca[0]), .i_CfgData(cd[0]), .o_VoiceOperator(vop[0]), .o_OperatorValid(vld[0]),
    .o_SampleStart(ss[0]), .o_PhaseStepConfigWriteEnable(we[0]),
    .o_PhaseStepConfigWriteAddr(wa[0]), .o_PhaseStepConfigWriteData(wd[0]), .o_Overrun(ovr[0]));

  voice_operator_sequencer #(.NUM_OPS(NOPS), .CLOCKS_PER_SAMPLE(CPS1), .PIPE_DEPTH(PD)) dut1 (
    .i_Clock(clk), .i_Reset(rst_s[1]), .i_CfgValid(cv[1]), .o_CfgReady(rdy[1]),
    .i_CfgAddr(ca[1]), .i_CfgData(cd[1]), .o_VoiceOperator(vop[1]), .o_OperatorValid(vld[1]),
    .o_SampleStart(ss[1]), .o_PhaseStepConfigWriteEnable(we[1]),
    .o_PhaseStepConfigWriteAddr(wa[1]), .o_PhaseStepConfigWriteData(wd[1]), .o_Overrun(ovr[1]));

  int errors = 0;
  int checks = 0;
  int cur_cyc = 0;

  // Model: what each sequencer is doing this cycle, plus the host writes still waiting.
  int          m_cnt [2], m_run [2], m_drain [2], m_beat [2], m_tickw [2], m_used [2], m_ovr [2];
  logic [23:0] mq [2][8];
  int          mq_n [2];
  logic [23:0] e_ent [2];
  int          e_valid [2], e_id [2], e_ss [2], e_we [2], e_addr [2], e_data [2], e_ready [2];

  task automatic check_eq(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", tag, k, cur_cyc, obs, exp);
    end
  endtask

  function automatic int cps_of(input int k);
    return (k == 0) ? CPS0 : CPS1;
  endfunction

  // Advance the model by one clock given this cycle's reset and accepted host write.
  task automatic model_step(input int k, input bit rst, input bit push, input logic [23:0] pent);
    bit tick, nonempty_before, start;
    if (rst) begin
      m_cnt[k] = 0; m_run[k] = -1; m_drain[k] = -1; m_beat[k] = 0;
      m_tickw[k] = 0; m_used[k] = 0; m_ovr[k] = 0; mq_n[k] = 0;
      e_valid[k] = 0; e_id[k] = 0; e_ss[k] = 0; e_we[k] = 0;
      e_addr[k] = 0; e_data[k] = 0; e_ready[k] = 0;
      return;
    end
    tick = (m_cnt[k] == cps_of(k) - 1);
    nonempty_before = (mq_n[k] > 0);
    start = 1'b0;
    if (tick && (m_run[k] >= 0 || m_drain[k] >= 0)) m_ovr[k] = 1;
    if (m_beat[k] == 2) begin
      for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
      mq_n[k]--;
    end
    if (push) begin
      mq[k][mq_n[k]] = pent;
      mq_n[k]++;
    end
    if (m_run[k] >= 0) begin
      if (m_run[k] == NOPS - 1) begin m_run[k] = -1; m_drain[k] = 0; end
      else m_run[k]++;
    end else if (m_drain[k] >= 0) begin
      if (m_drain[k] == PD - 1) m_drain[k] = -1;
      else m_drain[k]++;
    end else if (m_beat[k] == 1) begin
      m_beat[k] = 2;
      if (tick) m_tickw[k] = 1;
    end else if (m_beat[k] == 2) begin
      m_beat[k] = 0;
      m_used[k] = 1;
      if (tick || m_tickw[k] != 0) start = 1'b1;
      else if (FIFO && mq_n[k] > 0) m_beat[k] = 1;
    end else begin
      if (tick) start = 1'b1;
      else if (nonempty_before && (FIFO || m_used[k] == 0)) m_beat[k] = 1;
    end
    if (start) begin m_run[k] = 0; m_tickw[k] = 0; m_used[k] = 0; end
    e_valid[k] = (m_run[k] >= 0) ? 1 : 0;
    if (m_run[k] >= 0) e_id[k] = m_run[k];
    e_ss[k] = start ? 1 : 0;
    e_we[k] = (m_beat[k] == 1) ? 1 : (m_beat[k] == 2) ? 2 : 0;
    if (m_beat[k] == 1) begin
      e_ent[k]  = mq[k][0];
      e_addr[k] = int'(e_ent[k][23:16]);
      e_data[k] = int'(e_ent[k][15:8]);
    end else if (m_beat[k] == 2) begin
      e_data[k] = int'(e_ent[k][7:0]);
    end
    e_ready[k] = (mq_n[k] < QDEPTH) ? 1 : 0;
    m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
  endtask

  initial begin
    bit reset_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; cv[k] = 1'b0; ca[k] = 8'd0; cd[k] = 16'd0;
    end
    for (int cyc = 0; cyc < 3300; cyc++) begin
      @(negedge clk);
      cur_cyc = cyc;
      if (cyc > 0) begin
        for (int k = 0; k < 2; k++) begin
          check_eq("valid", k, 32'(vld[k]), e_valid[k]);
          check_eq("op_id", k, 32'(vop[k]), e_id[k]);
          check_eq("sample_start", k, 32'(ss[k]), e_ss[k]);
          check_eq("wr_en", k, 32'(we[k]), e_we[k]);
          check_eq("wr_addr", k, 32'(wa[k]), e_addr[k]);
          check_eq("wr_data", k, 32'(wd[k]), e_data[k]);
          check_eq("overrun", k, 32'(ovr[k]), m_ovr[k]);
          check_eq("cfg_ready", k, 32'(rdy[k]), e_ready[k]);
        end
      end
      rst_s[0] = (cyc < 3);
      rst_s[1] = (cyc < 3);
      if (!reset_done && cyc > 1500 && e_valid[0] == 1 && e_id[0] == 100) begin
        rst_s[0] = 1'b1;
        reset_done = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        cv[k] = ($urandom_range(0, 5) == 0);
        ca[k] = 8'($urandom);
        cd[k] = 16'($urandom);
        model_step(k, rst_s[k], cv[k] && (e_ready[k] != 0), {ca[k], cd[k]});
      end
    end
    if (!reset_done) begin
      errors++;
      $display("FAIL reset_inject dut0 cyc=%0d got=0 expected=1", cur_cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
